// File: rtl/reg_access_pkg.sv
// Shared widths, FSM state encoding and queued-command layout for the
// register access controller.
package reg_access_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 20;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/reg_cmd_fifo.sv
// Command FIFO for the register access controller. Pointers carry an extra
// wrap bit so that full and empty can be told apart.
module reg_cmd_fifo
    import reg_access_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    cmd_t           mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// Queues register read/write requests and executes them one at a time
// against a register memory with fixed read latency.
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData
);

    localparam int LAT_CNT_W = $clog2(RD_LATENCY + 1);

    state_t               state;
    logic                 op_write;
    logic [LAT_CNT_W-1:0] lat_cnt;
    cmd_t                 push_cmd;
    cmd_t                 head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    assign push_cmd  = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign req_ready = !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;

    reg_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_valid),
        .push_data(push_cmd),
        .pop      (pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Bus strobes default low each cycle and are loaded at pop time, so
    // they appear for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
        end else begin
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            Address <= '0;
            WrData  <= '0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        op_write <= head.write;
                        WrEn     <= head.write;
                        RdEn     <= !head.write;
                        Address  <= head.addr;
                        WrData   <= head.write ? head.wdata : '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_write) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= '0;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_CNT_W'(RD_LATENCY - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= RdData;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_write <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
